mul_div_seq: RTL

MUL_DIV_SEQ -- requirements
Module: mul_div_seq

---
 rtl/mul_div_seq_if.sv | 31 +++
 rtl/mul_div_seq.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mul_div_seq_if.sv
// mul_div_seq_if: operation/bus bundle for the sequential multiply/divide unit.
//   Start   - operation request (sampled only while the unit is idle)
//   Op      - 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   DA, DB  - operands; DA is also the direct HI/LO write data
//   Write   - direct HI/LO load, SelHL picks HI (1) or LO (0) for Write and DC
//   DC      - read data, SelHL ? HI : LO
//   Busy, Done, DivZero - status back to the requester
interface mul_div_seq_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic [1:0]       Op;
  logic [WIDTH-1:0] DA;
  logic [WIDTH-1:0] DB;
  logic             Write;
  logic             SelHL;
  logic [WIDTH-1:0] DC;
  logic             Busy;
  logic             Done;
  logic             DivZero;

  modport master (
    output Start, Op, DA, DB, Write, SelHL,
    input  DC, Busy, Done, DivZero
  );

  modport slave (
    input  Start, Op, DA, DB, Write, SelHL,
    output DC, Busy, Done, DivZero
  );
endinterface

// File: rtl/mul_div_seq.sv
// mul_div_seq: iterative radix-2 multiply/divide unit with HI/LO result registers.
//   Clk   - clock, all state changes on the rising edge
//   Reset - synchronous active-high reset; aborts any operation in flight
//   bus   - mul_div_seq_if slave port (Start/Op/DA/DB/Write/SelHL in,
//           DC/Busy/Done/DivZero out)
// An operation takes WIDTH+1 cycles: WIDTH iteration steps in CALC, then one
// FIN cycle that sign-corrects the magnitude result and writes HI/LO.
module mul_div_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic          Clk,
  input  logic          Reset,
  mul_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIN} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic             is_div_reg, sign_a_reg, sign_b_reg;
  logic [WIDTH-1:0] a_reg, b_reg;      // operand magnitudes
  logic [WIDTH-1:0] rem_reg, q_reg;    // working pair: {hi,lo} for multiply, {rem,quot} for divide
  logic [WIDTH-1:0] hi_reg, lo_reg;
  logic             done_reg, div_zero_reg;
  logic             busy;

  // Operand magnitude capture; only the signed ops (Op[0]=1) look at sign bits.
  logic             sign_da, sign_db;
  logic [WIDTH-1:0] abs_da, abs_db;
  assign sign_da = bus.Op[0] & bus.DA[WIDTH-1];
  assign sign_db = bus.Op[0] & bus.DB[WIDTH-1];
  assign abs_da  = sign_da ? (~bus.DA + 1'b1) : bus.DA;
  assign abs_db  = sign_db ? (~bus.DB + 1'b1) : bus.DB;

  logic last_step;
  assign last_step = (cnt_reg == CNT_W'(WIDTH - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk) begin
    if (Reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (bus.Start) state_next = S_CALC;
      S_CALC:  if (last_step) state_next = S_FIN;
      S_FIN:   state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state_reg != S_IDLE);
  end

  // ---------------- one iteration step ----------------
  // Multiply: add the multiplicand when the multiplier LSB is set, then shift
  // the {hi,lo} pair right; the multiplier bits drain out of q_reg as product
  // bits shift in.
  logic [WIDTH:0]   mul_sum;
  // Divide (restoring): shift {rem,quot} left, subtract the divisor when it fits.
  // The remainder stays below the divisor, so it never needs more than WIDTH bits.
  logic [WIDTH:0]   div_shift;
  logic             div_fits;
  logic [WIDTH-1:0] div_diff;
  logic [WIDTH-1:0] rem_step, q_step;

  assign mul_sum   = {1'b0, rem_reg} + (q_reg[0] ? {1'b0, a_reg} : '0);
  assign div_shift = {rem_reg, q_reg[WIDTH-1]};
  assign div_fits  = (div_shift >= {1'b0, b_reg});
  assign div_diff  = div_shift[WIDTH-1:0] - b_reg;

  always_comb begin
    rem_step = '0;
    q_step   = '0;
    if (is_div_reg) begin
      rem_step = div_fits ? div_diff : div_shift[WIDTH-1:0];
      q_step   = {q_reg[WIDTH-2:0], div_fits};
    end else begin
      rem_step = mul_sum[WIDTH:1];
      q_step   = {mul_sum[0], q_reg[WIDTH-1:1]};
    end
  end

  // ---------------- sign correction for the FIN write ----------------
  logic [2*WIDTH-1:0] prod, prod_neg;
  logic [WIDTH-1:0]   q_neg, rem_neg;
  logic               res_neg, div_by_zero;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod        = {rem_reg, q_reg};
  assign prod_neg    = ~prod + 1'b1;
  assign q_neg       = ~q_reg + 1'b1;
  assign rem_neg     = ~rem_reg + 1'b1;
  assign res_neg     = sign_a_reg ^ sign_b_reg;
  assign div_by_zero = (b_reg == '0);

  // With a zero divisor the restoring loop already leaves |DA| in the remainder;
  // undoing the dividend sign recovers DA exactly, and the quotient is forced
  // to all ones regardless of operand signs.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_div_reg) begin
      res_hi = sign_a_reg ? rem_neg : rem_reg;
      res_lo = div_by_zero ? '1 : (res_neg ? q_neg : q_reg);
    end else begin
      {res_hi, res_lo} = res_neg ? prod_neg : prod;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_reg      <= '0;
      is_div_reg   <= 1'b0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      a_reg        <= '0;
      b_reg        <= '0;
      rem_reg      <= '0;
      q_reg        <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg <= (state_reg == S_FIN);
      case (state_reg)
        S_IDLE: begin
          if (bus.Start) begin
            is_div_reg <= bus.Op[1];
            sign_a_reg <= sign_da;
            sign_b_reg <= sign_db;
            a_reg      <= abs_da;
            b_reg      <= abs_db;
            rem_reg    <= '0;
            q_reg      <= bus.Op[1] ? abs_da : abs_db;
            cnt_reg    <= '0;
          end else if (bus.Write) begin
            if (bus.SelHL) hi_reg <= bus.DA;
            else           lo_reg <= bus.DA;
          end
        end
        S_CALC: begin
          rem_reg <= rem_step;
          q_reg   <= q_step;
          cnt_reg <= cnt_reg + 1'b1;
        end
        S_FIN: begin
          hi_reg       <= res_hi;
          lo_reg       <= res_lo;
          div_zero_reg <= is_div_reg & div_by_zero;
        end
        default: ;
      endcase
    end
  end

  assign bus.DC      = bus.SelHL ? hi_reg : lo_reg;
  assign bus.Busy    = busy;
  assign bus.Done    = done_reg;
  assign bus.DivZero = div_zero_reg;

endmodule
